// File: rtl/respondedor_ram_if.sv
// Cache-to-RAM request/response bus: one request (optional writeback plus optional fill)
// in, one response out, each with a valid/ready handshake.
interface respondedor_ram_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wb;
  logic [7:0] req_wb_addr;
  logic [7:0] req_wb_data;
  logic       req_fill;
  logic [7:0] req_fill_addr;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;

  modport master (
    output req_valid, req_wb, req_wb_addr, req_wb_data, req_fill, req_fill_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_wb, req_wb_addr, req_wb_data, req_fill, req_fill_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/respondedor_ram.sv
// Backing-memory responder: 256x8 RAM serving a writeback and/or a line fill per request,
// each access costing LATENCY cycles, with exactly one response per accepted request.
module respondedor_ram #(
  parameter int unsigned LATENCY = 3
) (
  input  logic                clock,
  input  logic                resetn,
  respondedor_ram_if.slave    bus,
  output logic                busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWb   = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  localparam logic [7:0] MemInit [256] = '{
    100: 8'd5, 101: 8'd3, 102: 8'd1, 103: 8'd0, default: 8'd0
  };

  // Power-up contents only; reset deliberately leaves the array alone.
  logic [7:0] mem_q [256] = MemInit;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wb_q, wb_d;
  logic [7:0] wb_addr_q, wb_addr_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic       fill_q, fill_d;
  logic [7:0] fill_addr_q, fill_addr_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       mem_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_d        = wb_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_d      = fill_q;
    fill_addr_d = fill_addr_q;
    resp_data_d = resp_data_q;
    mem_we      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          wb_d        = bus.req_wb;
          wb_addr_d   = bus.req_wb_addr;
          wb_data_d   = bus.req_wb_data;
          fill_d      = bus.req_fill;
          fill_addr_d = bus.req_fill_addr;
          if (bus.req_wb) begin
            state_d = StWb;
            cnt_d   = CntLoad;
          end else if (bus.req_fill) begin
            state_d = StRd;
            cnt_d   = CntLoad;
          end else begin
            // Null request spends one cycle in RD with no fill so it answers at k+1.
            state_d = StRd;
            cnt_d   = 4'd0;
          end
        end
      end
      StWb: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we = 1'b1;
          if (fill_q) begin
            state_d = StRd;
            cnt_d   = CntLoad;
          end else begin
            state_d     = StResp;
            resp_data_d = 8'h00;
          end
        end
      end
      StRd: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_data_d = fill_q ? mem_q[fill_addr_q] : 8'h00;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wb_q        <= 1'b0;
      wb_addr_q   <= 8'h00;
      wb_data_q   <= 8'h00;
      fill_q      <= 1'b0;
      fill_addr_q <= 8'h00;
      resp_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_q        <= wb_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_q      <= fill_d;
      fill_addr_q <= fill_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  // mem_we only fires in WB, so wb_q is implied; kept latched for visibility.
  always_ff @(posedge clock) begin
    if (mem_we && wb_q) begin
      mem_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state_q != StIdle);

endmodule
